// File: rtl/mlp_infer_sched.sv
`default_nettype none
// ============================================================================
// Module   : mlp_infer_sched
// Purpose  : Single-row inference sequencer for a FEATURES-in / HIDDEN /
//            1-out perceptron stored as IEEE-754 doubles. Walks the feature
//            and weight memories, streams (activation, weight) pairs to an
//            external multiply-accumulate unit over valid/ready, keeps the
//            hidden results in a local register file, runs the output neuron
//            from them and returns the prediction.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            start, abort        - row start pulse / synchronous abort
//            row_base            - feature address of the row's first feature
//            busy, done, y       - status, completion pulse, prediction
//            feat_addr/rdata     - feature memory port (1-cycle read latency)
//            wt_addr/rdata       - weight memory port (1-cycle read latency)
//            mac_valid/ready     - operand handshake to the MAC
//            mac_a, mac_b        - activation and weight operands
//            mac_first/last      - first / last term of the current neuron
//            acc_valid/data      - accumulated sum returned by the MAC
// Options  : MLP_INFER_SCHED_RELU_EN - ReLU on the hidden layer when defined,
//            linear hidden layer otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module mlp_infer_sched #(
  parameter int FEATURES = 15,
  parameter int HIDDEN   = 10,
  parameter int DW       = 64,
  parameter int AW       = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] row_base,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] y,
  output logic [AW-1:0] feat_addr,
  input  logic [DW-1:0] feat_rdata,
  output logic [AW-1:0] wt_addr,
  input  logic [DW-1:0] wt_rdata,
  output logic          mac_valid,
  input  logic          mac_ready,
  output logic [DW-1:0] mac_a,
  output logic [DW-1:0] mac_b,
  output logic          mac_first,
  output logic          mac_last,
  input  logic          acc_valid,
  input  logic [DW-1:0] acc_data
);

  // Terms per hidden neuron, including the bias term.
  localparam int c_TERMS_H = FEATURES + 1;
  // Largest term index used by either layer (the bias index).
  localparam int c_MAX_J   = (FEATURES > HIDDEN) ? FEATURES : HIDDEN;
  localparam int c_JW      = $clog2(c_MAX_J + 1);
  localparam int c_NW      = $clog2(HIDDEN);
  // Output-neuron weights follow directly after all hidden-neuron weights.
  localparam logic [AW-1:0] c_WT_OUT_BASE = AW'(HIDDEN * c_TERMS_H);
  // Bias terms are issued as 1.0 * bias_weight.
  localparam logic [DW-1:0] c_ONE = DW'(64'h3FF0000000000000);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT_ACC = 3'd3,
    S_WRITE    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [AW-1:0]   r_row_base;
  logic            r_layer_out;   // 0: hidden layer, 1: output neuron
  logic [c_NW-1:0] r_n;           // hidden neuron index
  logic [c_JW-1:0] r_j;           // term index within the neuron
  logic [DW-1:0]   r_mid [HIDDEN];
  logic [DW-1:0]   r_y;
  logic [DW-1:0]   r_acc;
  // Set only during the first ISSUE cycle of a term: operands come straight
  // from the memory read data then and are captured into the hold registers,
  // which drive the MAC for any further (stalled) ISSUE cycles.
  logic            r_issue_first;
  logic [DW-1:0]   r_a_hold;
  logic [DW-1:0]   r_b_hold;

  logic            w_first;
  logic            w_last;
  logic [c_NW-1:0] w_mid_idx;
  logic [DW-1:0]   w_a_sel;

  // Hidden-layer activation.
  function automatic logic [DW-1:0] act(input logic [DW-1:0] x);
`ifdef MLP_INFER_SCHED_RELU_EN
    // Sign bit set covers both negative values and -0.0; both map to +0.0.
    act = x[DW-1] ? '0 : x;
`else
    act = x;
`endif
  endfunction

  // --------------------------------------------------------------------------
  // Term bookkeeping and operand selection
  // --------------------------------------------------------------------------
  assign w_first   = (r_j == '0);
  // The last term of every neuron is its bias term.
  assign w_last    = r_layer_out ? (r_j == c_JW'(HIDDEN)) : (r_j == c_JW'(FEATURES));
  assign w_mid_idx = r_j[c_NW-1:0];

  always_comb begin
    w_a_sel = c_ONE;
    if (!w_last) begin
      if (r_layer_out) begin
        w_a_sel = r_mid[w_mid_idx];
      end else begin
        w_a_sel = feat_rdata;
      end
    end
  end

  // Addresses are derived from the term counters, so they are stable for the
  // whole FETCH/ISSUE span of a term. Arithmetic wraps modulo 2^AW.
  assign feat_addr = r_row_base + AW'(r_j);
  assign wt_addr   = r_layer_out ? (c_WT_OUT_BASE + AW'(r_j))
                                 : (AW'(r_n) * AW'(c_TERMS_H) + AW'(r_j));
  assign y         = r_y;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and handshake / status outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    mac_valid    = 1'b0;
    mac_first    = 1'b0;
    mac_last     = 1'b0;
    mac_a        = r_issue_first ? w_a_sel  : r_a_hold;
    mac_b        = r_issue_first ? wt_rdata : r_b_hold;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        busy         = 1'b1;
        w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        busy      = 1'b1;
        mac_valid = 1'b1;
        mac_first = w_first;
        mac_last  = w_last;
        if (mac_ready) begin
          w_state_next = w_last ? S_WAIT_ACC : S_FETCH;
        end
      end
      S_WAIT_ACC: begin
        busy = 1'b1;
        if (acc_valid) begin
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        busy         = 1'b1;
        w_state_next = r_layer_out ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Abort wins over every transition except out of IDLE.
    if (abort && (r_state != S_IDLE)) begin
      w_state_next = S_IDLE;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_base    <= '0;
      r_layer_out   <= 1'b0;
      r_n           <= '0;
      r_j           <= '0;
      r_y           <= '0;
      r_acc         <= '0;
      r_issue_first <= 1'b0;
      r_a_hold      <= '0;
      r_b_hold      <= '0;
      for (int i = 0; i < HIDDEN; i++) begin
        r_mid[i] <= '0;
      end
    end else begin
      r_issue_first <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row_base  <= row_base;
            r_layer_out <= 1'b0;
            r_n         <= '0;
            r_j         <= '0;
          end
        end
        S_FETCH: begin
          if (!abort) begin
            r_issue_first <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (r_issue_first) begin
            r_a_hold <= w_a_sel;
            r_b_hold <= wt_rdata;
          end
          if (mac_ready && !w_last && !abort) begin
            r_j <= r_j + 1'b1;
          end
        end
        S_WAIT_ACC: begin
          if (acc_valid && !abort) begin
            r_acc <= acc_data;
          end
        end
        S_WRITE: begin
          if (!abort) begin
            if (r_layer_out) begin
              // The output neuron is never activated.
              r_y <= r_acc;
            end else begin
              r_mid[r_n] <= act(r_acc);
              r_j        <= '0;
              if (r_n == c_NW'(HIDDEN - 1)) begin
                r_layer_out <= 1'b1;
              end else begin
                r_n <= r_n + 1'b1;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mlp_infer_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mlp_infer_sched
// Purpose  : Directed self-checking bench for mlp_infer_sched. Provides
//            feature/weight memories with one-cycle read latency and a
//            behavioural double-precision MAC returning the sum one cycle
//            after the last accepted term.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mlp_infer_sched;

  localparam int AW = 11;
  localparam int DW = 64;

  localparam logic [63:0] C_ZERO  = 64'h0000000000000000;
  localparam logic [63:0] C_ONE   = 64'h3FF0000000000000;
  localparam logic [63:0] C_HALF  = 64'h3FE0000000000000;
  localparam logic [63:0] C_MONE  = 64'hBFF0000000000000;
  localparam logic [63:0] C_TWO   = 64'h4000000000000000;
  localparam logic [63:0] Y_37P5  = 64'h4042C00000000000;  // 37.5
  localparam logic [63:0] Y_75    = 64'h4052C00000000000;  // 75.0
  localparam logic [63:0] Y_M148  = 64'hC062800000000000;  // -148.0

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [AW-1:0] row_base;
  logic          busy;
  logic          done;
  logic [DW-1:0] y;
  logic [AW-1:0] feat_addr;
  logic [DW-1:0] feat_rdata;
  logic [AW-1:0] wt_addr;
  logic [DW-1:0] wt_rdata;
  logic          mac_valid;
  logic          mac_ready;
  logic [DW-1:0] mac_a;
  logic [DW-1:0] mac_b;
  logic          mac_first;
  logic          mac_last;
  logic          acc_valid;
  logic [DW-1:0] acc_data;

  int n_pass  = 0;
  int n_total = 0;

  mlp_infer_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .row_base   (row_base),
    .busy       (busy),
    .done       (done),
    .y          (y),
    .feat_addr  (feat_addr),
    .feat_rdata (feat_rdata),
    .wt_addr    (wt_addr),
    .wt_rdata   (wt_rdata),
    .mac_valid  (mac_valid),
    .mac_ready  (mac_ready),
    .mac_a      (mac_a),
    .mac_b      (mac_b),
    .mac_first  (mac_first),
    .mac_last   (mac_last),
    .acc_valid  (acc_valid),
    .acc_data   (acc_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- memories
  logic [63:0] feat_mem [0:2047];
  logic [63:0] wt_mem   [0:2047];

  always @(posedge clk) begin : mem_model
    logic [AW-1:0] fa;
    logic [AW-1:0] wa;
    fa = feat_addr;
    wa = wt_addr;
    #1;
    feat_rdata = feat_mem[fa];
    wt_rdata   = wt_mem[wa];
  end

  // -------------------------------------------------------------- MAC model
  logic        rand_ready = 1'b0;

  always @(posedge clk) begin : ready_drv
    #1;
    mac_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  real           acc_r;
  int            n_acc_total  = 0;
  int            n_stall_viol = 0;
  logic          stalled      = 1'b0;
  logic [63:0]   pa, pb;
  logic          pf, pl;
  logic [AW-1:0] tr_wt    [0:2047];
  logic [AW-1:0] tr_feat  [0:2047];
  logic          tr_first [0:2047];
  logic          tr_last  [0:2047];

  always @(posedge clk) begin : mac_model
    logic fire;
    fire = 1'b0;
    if (stalled && (mac_valid !== 1'b1 || mac_a !== pa || mac_b !== pb ||
                    mac_first !== pf || mac_last !== pl)) begin
      n_stall_viol++;
    end
    stalled = mac_valid && !mac_ready;
    pa = mac_a;
    pb = mac_b;
    pf = mac_first;
    pl = mac_last;
    if (mac_valid && mac_ready) begin
      if (mac_first) acc_r = $bitstoreal(mac_a) * $bitstoreal(mac_b);
      else           acc_r = acc_r + $bitstoreal(mac_a) * $bitstoreal(mac_b);
      if (n_acc_total < 2048) begin
        tr_wt[n_acc_total]    = wt_addr;
        tr_feat[n_acc_total]  = feat_addr;
        tr_first[n_acc_total] = mac_first;
        tr_last[n_acc_total]  = mac_last;
      end
      n_acc_total++;
      fire = mac_last;
    end
    #1;
    acc_valid = fire;
    acc_data  = fire ? $realtobits(acc_r) : 64'h0;
  end

  // ---------------------------------------------------------------- helpers
  task automatic load_mem(input int base, input logic [63:0] fv, input logic [63:0] hw,
                          input logic [63:0] ow, input logic [63:0] ob);
    for (int i = 0; i < 15; i++) feat_mem[base + i] = fv;
    for (int n = 0; n < 10; n++) begin
      for (int j = 0; j < 15; j++) wt_mem[n * 16 + j] = hw;
      wt_mem[n * 16 + 15] = C_ZERO;
    end
    for (int j = 0; j < 10; j++) wt_mem[160 + j] = ow;
    wt_mem[170] = ob;
  endtask

  // Pulses start and waits (bounded) for done. cyc counts edges from the
  // edge that samples start (that edge is cycle 1).
  task automatic run_row(input logic [AW-1:0] base, input int inject_at,
                         input logic [AW-1:0] inject_base,
                         output int cyc, output logic got, output logic busy1);
    row_base = base;
    start    = 1'b1;
    cyc      = 0;
    got      = 1'b0;
    busy1    = 1'b0;
    while (!got && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      if (cyc == 1) busy1 = busy;
      if (cyc == inject_at) begin
        start    = 1'b1;
        row_base = inject_base;
      end
      if (done) got = 1'b1;
    end
    start = 1'b0;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (busy !== 1'b0)      $display("FAIL reset_busy: got %b exp 0", busy);           else n_pass++;
    n_total++; if (done !== 1'b0)      $display("FAIL reset_done: got %b exp 0", done);           else n_pass++;
    n_total++; if (y !== 64'h0)        $display("FAIL reset_y: got %h exp 0", y);                 else n_pass++;
    n_total++; if (feat_addr !== '0)   $display("FAIL reset_feat_addr: got %h exp 0", feat_addr); else n_pass++;
    n_total++; if (wt_addr !== '0)     $display("FAIL reset_wt_addr: got %h exp 0", wt_addr);     else n_pass++;
    n_total++; if (mac_valid !== 1'b0) $display("FAIL reset_mac_valid: got %b exp 0", mac_valid); else n_pass++;
    n_total++; if (mac_a !== 64'h0)    $display("FAIL reset_mac_a: got %h exp 0", mac_a);         else n_pass++;
    n_total++; if (mac_b !== 64'h0)    $display("FAIL reset_mac_b: got %h exp 0", mac_b);         else n_pass++;
    n_total++; if (mac_first !== 1'b0) $display("FAIL reset_mac_first: got %b exp 0", mac_first); else n_pass++;
    n_total++; if (mac_last !== 1'b0)  $display("FAIL reset_mac_last: got %b exp 0", mac_last);   else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic(output int tr_base);
    int   cyc;
    logic got;
    logic b1;
    load_mem(32, C_ONE, C_HALF, C_HALF, C_ZERO);
    rand_ready = 1'b0;
    @(posedge clk); #1;
    tr_base = n_acc_total;
    n_total++; if (busy !== 1'b0) $display("FAIL basic_busy_pre: got %b exp 0", busy); else n_pass++;
    run_row(11'd32, 0, 11'd0, cyc, got, b1);
    n_total++; if (got !== 1'b1) $display("FAIL basic_done_seen: got %b exp 1", got); else n_pass++;
    n_total++; if (b1 !== 1'b1)  $display("FAIL basic_busy_rise: got %b exp 1", b1); else n_pass++;
    n_total++; if (cyc != 365)   $display("FAIL basic_latency: got %0d exp 365", cyc); else n_pass++;
    n_total++; if (y !== Y_37P5) $display("FAIL basic_y: got %h exp %h", y, Y_37P5); else n_pass++;
    n_total++; if (n_acc_total - tr_base != 171)
      $display("FAIL basic_accepts: got %0d exp 171", n_acc_total - tr_base); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b exp 0", done); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL basic_busy_after: got %b exp 0", busy); else n_pass++;
    n_total++; if (y !== Y_37P5)  $display("FAIL basic_y_held: got %h exp %h", y, Y_37P5); else n_pass++;
  endtask

  task automatic test_addr_trace(input int tr_base);
    for (int k = 0; k < 171; k++) begin
      int   j;
      logic ef, el;
      if (k < 160) begin
        j  = k % 16;
        ef = (j == 0);
        el = (j == 15);
        if (j < 15) begin
          n_total++;
          if (tr_feat[tr_base + k] !== AW'(32 + j))
            $display("FAIL trace_feat[%0d]: got %0d exp %0d", k, tr_feat[tr_base + k], 32 + j);
          else n_pass++;
        end
      end else begin
        j  = k - 160;
        ef = (j == 0);
        el = (j == 10);
      end
      n_total++;
      if (tr_wt[tr_base + k] !== AW'(k))
        $display("FAIL trace_wt[%0d]: got %0d exp %0d", k, tr_wt[tr_base + k], k);
      else n_pass++;
      n_total++;
      if (tr_first[tr_base + k] !== ef || tr_last[tr_base + k] !== el)
        $display("FAIL trace_flags[%0d]: got %b%b exp %b%b", k,
                 tr_first[tr_base + k], tr_last[tr_base + k], ef, el);
      else n_pass++;
    end
  endtask

  task automatic test_random_ready();
    int   cyc;
    logic got;
    logic b1;
    int   a0;
    int   v0;
    rand_ready = 1'b1;
    a0 = n_acc_total;
    v0 = n_stall_viol;
    run_row(11'd32, 0, 11'd0, cyc, got, b1);
    rand_ready = 1'b0;
    n_total++; if (got !== 1'b1) $display("FAIL rnd_done_seen: got %b exp 1", got); else n_pass++;
    n_total++; if (y !== Y_37P5) $display("FAIL rnd_y: got %h exp %h", y, Y_37P5); else n_pass++;
    n_total++; if (n_acc_total - a0 != 171)
      $display("FAIL rnd_accepts: got %0d exp 171", n_acc_total - a0); else n_pass++;
    n_total++; if (n_stall_viol - v0 != 0)
      $display("FAIL rnd_stall_stable: got %0d changes exp 0", n_stall_viol - v0); else n_pass++;
    n_total++; if (cyc <= 365) $display("FAIL rnd_stalls_seen: got %0d cycles exp >365", cyc); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    logic saw_done;
    row_base = 11'd32;
    start    = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    n_total++; if (busy !== 1'b1) $display("FAIL abort_busy_before: got %b exp 1", busy); else n_pass++;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL abort_busy_low: got %b exp 0", busy); else n_pass++;
    saw_done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    n_total++; if (saw_done !== 1'b0) $display("FAIL abort_no_done: got %b exp 0", saw_done); else n_pass++;
    n_total++; if (y !== Y_37P5) $display("FAIL abort_y_kept: got %h exp %h", y, Y_37P5); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int   cyc;
    logic got;
    logic b1;
    // Row at 500 uses features of 2.0; a stray start at cycle 50 pointing at
    // the 1.0 row must be ignored.
    load_mem(500, C_TWO, C_HALF, C_HALF, C_ZERO);
    run_row(11'd500, 50, 11'd32, cyc, got, b1);
    n_total++; if (got !== 1'b1) $display("FAIL b2b_done_seen: got %b exp 1", got); else n_pass++;
    n_total++; if (cyc != 365)   $display("FAIL b2b_latency: got %0d exp 365", cyc); else n_pass++;
    n_total++; if (y !== Y_75)   $display("FAIL b2b_y: got %h exp %h", y, Y_75); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    int   cyc;
    logic got;
    logic b1;
    row_base = 11'd32;
    start    = 1'b1;
    for (int c = 1; c <= 150; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_total++; if (busy !== 1'b0 || done !== 1'b0 || mac_valid !== 1'b0 ||
                   mac_first !== 1'b0 || mac_last !== 1'b0)
      $display("FAIL areset_ctrl: got busy=%b done=%b valid=%b first=%b last=%b exp all 0",
               busy, done, mac_valid, mac_first, mac_last); else n_pass++;
    n_total++; if (y !== 64'h0 || mac_a !== 64'h0 || mac_b !== 64'h0)
      $display("FAIL areset_data: got y=%h a=%h b=%h exp 0", y, mac_a, mac_b); else n_pass++;
    n_total++; if (feat_addr !== '0 || wt_addr !== '0)
      $display("FAIL areset_addr: got %0d/%0d exp 0/0", feat_addr, wt_addr); else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_total++; if (busy !== 1'b0 || mac_valid !== 1'b0)
        $display("FAIL areset_hold[%0d]: got busy=%b valid=%b exp 0", c, busy, mac_valid); else n_pass++;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_total++; if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL areset_idle: got busy=%b done=%b exp 0", busy, done); else n_pass++;
    run_row(11'd32, 0, 11'd0, cyc, got, b1);
    n_total++; if (got !== 1'b1) $display("FAIL areset_row_done: got %b exp 1", got); else n_pass++;
    n_total++; if (cyc != 365)   $display("FAIL areset_row_latency: got %0d exp 365", cyc); else n_pass++;
    n_total++; if (y !== Y_37P5) $display("FAIL areset_row_y: got %h exp %h", y, Y_37P5); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_activation();
    int          cyc;
    logic        got;
    logic        b1;
    logic [63:0] exp_y;
`ifdef MLP_INFER_SCHED_RELU_EN
    exp_y = C_TWO;
`else
    exp_y = Y_M148;
`endif
    load_mem(32, C_ONE, C_MONE, C_ONE, C_TWO);
    run_row(11'd32, 0, 11'd0, cyc, got, b1);
    n_total++; if (got !== 1'b1) $display("FAIL act_done_seen: got %b exp 1", got); else n_pass++;
    n_total++; if (y !== exp_y)  $display("FAIL act_y: got %h exp %h", y, exp_y); else n_pass++;
  endtask

  initial begin
    int tr_base;
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    row_base   = '0;
    mac_ready  = 1'b0;
    acc_valid  = 1'b0;
    acc_data   = '0;
    feat_rdata = '0;
    wt_rdata   = '0;
    for (int i = 0; i < 2048; i++) begin
      feat_mem[i] = 64'h0;
      wt_mem[i]   = 64'h0;
    end
    test_reset();
    test_basic(tr_base);
    test_addr_trace(tr_base);
    test_random_ready();
    test_abort();
    test_back_to_back();
    test_async_reset();
    test_activation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mlp_infer_sched.md
# mlp_infer_sched

Sequencer for single-row inference of the 15-input / 10-hidden / 1-output perceptron held in 64-bit IEEE-754 double memories. For one test row it walks the feature and weight memories and feeds operand pairs to a shared external floating-point multiply-accumulate unit over a valid/ready handshake. It stores the hidden-layer results in an internal register file, runs the output neuron from them, and returns the prediction. It sits between the test-data/weight memories and the MAC inside the prediction datapath.

## Interface
- FEATURES, 15, inputs per row (terms per hidden neuron = FEATURES+1 incl. bias)
- HIDDEN, 10, hidden neurons (terms for output neuron = HIDDEN+1 incl. bias)
- DW, 64, data width (IEEE-754 double bit pattern)
- AW, 11, address width of both memory ports
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a row when idle
- abort  in  1  synchronous; returns to IDLE next cycle, no done
- row_base  in  AW  feature-memory address of row's first feature, sampled on accepted start
- busy  out  1  high from accepted start until done or abort
- done  out  1  one-cycle pulse when y valid
- y  out  DW  prediction; held until next done
- feat_addr  out  AW  feature memory read address (data 1 cycle later)
- feat_rdata  in  DW  feature memory data
- wt_addr  out  AW  weight memory read address (data 1 cycle later)
- wt_rdata  in  DW  weight memory data
- mac_valid  out  1  operand pair valid
- mac_ready  in  1  MAC accepts pair when valid&ready
- mac_a, mac_b  out  DW  operands (activation, weight)
- mac_first  out  1  qualifies first term of a neuron (MAC clears accumulator)
- mac_last  out  1  qualifies last term of a neuron
- acc_valid  in  1  one-cycle pulse, accumulated sum ready
- acc_data  in  DW  accumulated sum

## Operation
- States: IDLE, FETCH, ISSUE, WAIT_ACC, WRITE, DONE.
- IDLE: start=1 → latch row_base, layer=HID, neuron n=0, term j=0, go FETCH. start while busy ignored.
- FETCH (1 cycle): drive addresses for term j.
  - Hidden layer: wt_addr = n*(FEATURES+1)+j; feat_addr = row_base+j (j<FEATURES).
  - Output layer: wt_addr = HIDDEN*(FEATURES+1)+j.
- ISSUE: mac_valid=1, mac_b=wt_rdata (registered in ISSUE's first cycle and held while stalled).
  - mac_a: feat_rdata (hidden, j<FEATURES); mid[j] (output, j<HIDDEN); constant 1.0 = 64'h3FF0000000000000 on bias term.
  - mac_first = (j==0); mac_last = (j==last term).
  - Hold all MAC outputs stable until mac_ready. On accept: if not last, j+1 → FETCH; else → WAIT_ACC.
- WAIT_ACC: wait for acc_valid; capture acc_data → WRITE. acc_valid outside WAIT_ACC ignored.
- WRITE (1 cycle):
  - Hidden layer: mid[n] = act(acc); if n<HIDDEN-1 → n+1, j=0, FETCH; else layer=OUT, j=0, FETCH.
  - Output layer: y = acc (never activated) → DONE.
- DONE: done=1 for one cycle, → IDLE.
- abort in any non-IDLE state → IDLE next edge; mid, y unchanged; no done.
- Address arithmetic unsigned, modulo 2^AW; no range check.

## Timing
- Reset values: busy=0, done=0, y=0, feat_addr=0, wt_addr=0, mac_valid=0, mac_a=0, mac_b=0, mac_first=0, mac_last=0, mid[*]=0, state IDLE.
- busy rises the cycle after start is sampled; falls with done.
- Per term, mac_ready=1: 2 cycles (FETCH+ISSUE). Each extra cycle of mac_ready=0 adds 1.
- Per neuron: 2·terms + L + 1 cycles, L = cycles from last accept to acc_valid.
- Row total with ready=1, L=1: 10·(32+2) + (22+2) + 1 = 365 cycles start-to-done.
- rst_n assertion mid-row forces the reset values immediately; the row is lost.

## Configuration
- MLP_INFER_SCHED_RELU_EN defined: hidden act(x) = 0 if x[63]==1, else x. This maps -0.0 to +0.0 and negative values to +0.0.
- Undefined: act(x)=x (linear hidden layer). The output layer is unaffected either way.

## Test plan
- Features all 1.0, every weight 0.5, all biases 0.0, mac_ready=1, L=1.
  - Each mid = 7.5 (15×0.5).
  - y = 10×7.5×0.5 = 37.5.
  - done exactly 365 cycles after start.
- Hidden weights -1.0 on features 1.0, output weights 1.0, output bias 2.0.
  - RELU_EN: y = 2.0.
  - Without: y = 10×(-15)+2 = -148.0.
- mac_ready random 50% duty.
  - y identical to the ready=1 run.
  - Operands never change while mac_valid & !mac_ready.
  - Exactly 171 accepts per row.
- Address trace with row_base=32.
  - feat_addr sequence 32..46 per hidden neuron.
  - wt_addr 0..159 in order, then 160..170.
  - mac_first/mac_last on terms 0 and 15 (hidden) and 0 and 10 (output).
- Robustness events:
  - abort at cycle 100 → busy low next cycle, no done.
  - Fresh start with a different row_base completes correctly.
  - start while busy ignored.
- Async reset mid-row (rst_n low 3 cycles) → all outputs at reset values during reset, IDLE after release; next start completes normally.
